// File: rtl/ber_checker.sv
// ber_checker: receive-side BER checker for the PRBS9/BPSK link.
// Finds the channel latency by exhaustive search over a local PRBS delay
// line, locks to the best candidate, then counts compared bits and errors.
// Ports:
//   clock, i_reset       - system clock, synchronous active-high reset
//   i_valid              - one-clock baud strobe qualifying i_tx_bit/i_rx_bit
//   i_enable             - RX enable; rising edge (re)starts the search
//   i_tx_bit, i_rx_bit   - local PRBS9 bit and sliced receive bit
//   o_locked             - high while locked
//   o_latency            - selected latency in baud periods
//   o_bit_count          - bits compared since lock (saturating)
//   o_error_count        - mismatches since lock (saturating)
//   o_ber_zero           - locked with zero errors
module ber_checker #(
  parameter int unsigned NB_COUNT = 64,
  parameter int unsigned NB_DELAY = 9,
  parameter int unsigned WINDOW   = 511
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_enable,
  input  logic                i_tx_bit,
  input  logic                i_rx_bit,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_latency,
  output logic [NB_COUNT-1:0] o_bit_count,
  output logic [NB_COUNT-1:0] o_error_count,
  output logic                o_ber_zero
);

  localparam int unsigned DEPTH = 1 << NB_DELAY;
  localparam int unsigned WW    = $clog2(WINDOW + 1);
  localparam logic [NB_DELAY-1:0] D_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOCKED} state_t;

  state_t              state_q, state_d;
  logic                en_q;
  logic [DEPTH-2:0]    dl_q, dl_d;
  logic [NB_DELAY-1:0] d_q, d_d;
  logic [NB_DELAY-1:0] best_q, best_d;
  logic [NB_DELAY-1:0] lat_q, lat_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [WW-1:0]       werr_q, werr_d;
  logic [WW-1:0]       min_q, min_d;
  logic [NB_COUNT-1:0] bit_q, bit_d;
  logic [NB_COUNT-1:0] err_q, err_d;
  logic                locked_q, locked_d;
  logic                ber_zero_q, ber_zero_d;

  // ref(0) is the current tx bit; ref(d>0) comes from the pre-shift delay line
  logic [DEPTH-1:0]    ref_vec;
  logic                mis_search, mis_locked;
  logic [WW-1:0]       wcnt_inc, werr_inc;

  assign ref_vec    = {dl_q, i_tx_bit};
  assign mis_search = i_rx_bit ^ ref_vec[d_q];
  assign mis_locked = i_rx_bit ^ ref_vec[lat_q];
  assign wcnt_inc   = wcnt_q + WW'(1);
  assign werr_inc   = werr_q + WW'(mis_search);

  // State register
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      dl_q       <= '0;
      d_q        <= '0;
      best_q     <= '0;
      lat_q      <= '0;
      wcnt_q     <= '0;
      werr_q     <= '0;
      min_q      <= '1;
      bit_q      <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      ber_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= i_enable;
      dl_q       <= dl_d;
      d_q        <= d_d;
      best_q     <= best_d;
      lat_q      <= lat_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      min_q      <= min_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      ber_zero_q <= ber_zero_d;
    end
  end

  // Next-state, search and counting logic
  always_comb begin
    state_d = state_q;
    dl_d    = dl_q;
    d_d     = d_q;
    best_d  = best_q;
    lat_d   = lat_q;
    wcnt_d  = wcnt_q;
    werr_d  = werr_q;
    min_d   = min_q;
    bit_d   = bit_q;
    err_d   = err_q;

    // Delay line runs on every strobe regardless of state
    if (i_valid) dl_d = ref_vec[DEPTH-2:0];

    case (state_q)
      S_IDLE: begin
        // en_q resets low, so enable held through reset also counts as a rise
        if (i_enable && !en_q) begin
          state_d = S_SEARCH;
          bit_d   = '0;
          err_d   = '0;
          lat_d   = '0;
          d_d     = '0;
          best_d  = '0;
          wcnt_d  = '0;
          werr_d  = '0;
          min_d   = '1;
        end
      end
      S_SEARCH: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (i_valid) begin
          wcnt_d = wcnt_inc;
          werr_d = werr_inc;
          if (wcnt_inc == WW'(WINDOW)) begin
            wcnt_d = '0;
            werr_d = '0;
            d_d    = d_q + NB_DELAY'(1);
            // Strict compare keeps the lowest d on ties
            if (werr_inc < min_q) begin
              min_d  = werr_inc;
              best_d = d_q;
            end
            if (d_q == D_LAST) begin
              state_d = S_LOCKED;
              lat_d   = best_d;
            end
          end
        end
      end
      S_LOCKED: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (i_valid) begin
          if (bit_q != '1) bit_d = bit_q + NB_COUNT'(1);
          if (mis_locked && (err_q != '1)) err_d = err_q + NB_COUNT'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    locked_d   = (state_d == S_LOCKED);
    ber_zero_d = locked_d && (err_d == '0);
  end

  assign o_locked      = locked_q;
  assign o_latency     = lat_q;
  assign o_bit_count   = bit_q;
  assign o_error_count = err_q;
  assign o_ber_zero    = ber_zero_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: scoreboard bench for ber_checker. A PRBS9 source feeds a
// 37-strobe channel delay; one instance (16-bit counters) checks search,
// lock, counting and control; a second (4-bit counters) checks saturation.
module tb_ber_checker;

  localparam int unsigned NBD = 6;
  localparam int unsigned WIN = 63;
  localparam int unsigned LAT = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, rst2 = 1'b0;
  logic valid = 1'b0, en = 1'b0, tx = 1'b0, rx = 1'b0, rx2 = 1'b0;

  logic           locked1, berz1;
  logic [NBD-1:0] lat1;
  logic [15:0]    bitc1, errc1;
  logic           locked2, berz2;
  logic [NBD-1:0] lat2;
  logic [3:0]     bitc2, errc2;

  ber_checker #(.NB_COUNT(16), .NB_DELAY(NBD), .WINDOW(WIN)) dut (
    .clock(clk), .i_reset(rst), .i_valid(valid), .i_enable(en),
    .i_tx_bit(tx), .i_rx_bit(rx),
    .o_locked(locked1), .o_latency(lat1), .o_bit_count(bitc1),
    .o_error_count(errc1), .o_ber_zero(berz1));

  ber_checker #(.NB_COUNT(4), .NB_DELAY(NBD), .WINDOW(WIN)) dut_sat (
    .clock(clk), .i_reset(rst2), .i_valid(valid), .i_enable(en),
    .i_tx_bit(tx), .i_rx_bit(rx2),
    .o_locked(locked2), .o_latency(lat2), .o_bit_count(bitc2),
    .o_error_count(errc2), .o_ber_zero(berz2));

  typedef struct {
    string       name;
    bit          sel;
    logic        locked;
    logic [15:0] lat;
    logic [15:0] bitc;
    logic [15:0] errc;
    logic        berz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Channel model state
  logic [8:0]  lfsr = 9'h1FF;
  logic [63:0] hist = '0;
  bit          sat_inv = 1'b0;

  task automatic chk(input string n, input string f, input logic [15:0] act,
                     input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, req);
    end
  endtask

  // Monitor: pop one expectation per negedge and compare against the DUT
  exp_t m;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      if (!m.sel) begin
        chk(m.name, "locked", 16'(locked1), 16'(m.locked));
        chk(m.name, "latency", 16'(lat1), m.lat);
        chk(m.name, "bit_count", bitc1, m.bitc);
        chk(m.name, "error_count", errc1, m.errc);
        chk(m.name, "ber_zero", 16'(berz1), 16'(m.berz));
      end else begin
        chk(m.name, "locked", 16'(locked2), 16'(m.locked));
        chk(m.name, "latency", 16'(lat2), m.lat);
        chk(m.name, "bit_count", 16'(bitc2), m.bitc);
        chk(m.name, "error_count", 16'(errc2), m.errc);
        chk(m.name, "ber_zero", 16'(berz2), 16'(m.berz));
      end
    end
  end

  task automatic expect_out(input string n, input bit sel, input logic l,
                            input int lat, input int b, input int e,
                            input logic z);
    exp_t x;
    x.name = n; x.sel = sel; x.locked = l; x.lat = 16'(lat);
    x.bitc = 16'(b); x.errc = 16'(e); x.berz = z;
    exp_q.push_back(x);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard_timeout pending=%0d required=0", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  // One baud strobe: drive for one sampled edge, then advance the channel
  task automatic strobe(input bit inj, input bit en_val);
    @(posedge clk); #1;
    tx    = lfsr[8];
    rx    = hist[LAT-1] ^ inj;
    rx2   = hist[LAT-1] ^ sat_inv;
    en    = en_val;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    hist  = {hist[62:0], lfsr[8]};
    lfsr  = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
  endtask

  task automatic run(input int n, input int inj_period);
    for (int i = 1; i <= n; i++)
      strobe((inj_period != 0) && (i % inj_period == 0), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    rst = 1'b1; rst2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid = 1'($urandom); en = 1'($urandom);
      tx = 1'($urandom); rx = 1'($urandom); rx2 = 1'($urandom);
      @(posedge clk); #1;
      expect_out($sformatf("reset%0d", i), 1'b0, 1'b0, 0, 0, 0, 1'b0);
      expect_out($sformatf("reset_sat%0d", i), 1'b1, 1'b0, 0, 0, 0, 1'b0);
      @(posedge clk); #1;
    end
    valid = 1'b0; en = 1'b0; rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    // Start searching, then drop enable mid-search and restart
    en = 1'b1;
    run(1000, 0);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    expect_out("enable_low", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 en = 1'b1;

    // Lock exactly 64 x 63 strobes after re-enable
    run(64 * 63 - 1, 0);
    expect_out("pre_lock", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    run(1, 0);
    expect_out("lock", 1'b0, 1'b1, LAT, 0, 0, 1'b1);
    expect_out("lock_sat", 1'b1, 1'b1, LAT, 0, 0, 1'b1);

    // Clean loopback counting; saturating instance sees all bits in error
    sat_inv = 1'b1;
    run(15, 0);
    expect_out("count15", 1'b0, 1'b1, LAT, 15, 0, 1'b1);
    expect_out("sat15", 1'b1, 1'b1, LAT, 15, 15, 1'b0);
    run(985, 0);
    expect_out("count1000", 1'b0, 1'b1, LAT, 1000, 0, 1'b1);
    expect_out("sat_hold", 1'b1, 1'b1, LAT, 15, 15, 1'b0);

    // Errors on every 100th strobe, then reset while five errors are logged
    run(500, 100);
    expect_out("err5", 1'b0, 1'b1, LAT, 1500, 5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_out("reset_locked", 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Enable stayed high through reset: fresh search
    run(64 * 63, 0);
    expect_out("relock", 1'b0, 1'b1, LAT, 0, 0, 1'b1);
    run(1000, 100);
    expect_out("inject1000", 1'b0, 1'b1, LAT, 1000, 10, 1'b0);

    // Strobe coincident with enable falling is not counted
    strobe(1'b1, 1'b0);
    expect_out("valid_en_fall", 1'b0, 1'b0, LAT, 1000, 10, 1'b0);
    expect_out("sat_final", 1'b1, 1'b0, LAT, 15, 15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
